// File: rtl/decade_slot_arbiter_if.sv
// Bus bundle for the decade slot arbiter.
// The master side drives enable/req/done and observes the grant state;
// the slave side is the arbiter itself.
interface decade_slot_arbiter_if;
   logic       enable;
   logic [9:0] req;
   logic       done;
   logic [9:0] gnt;
   logic [3:0] slot;
   logic       busy;
   logic       wrap;
   logic       timeout;

   modport master (
      output enable, req, done,
      input  gnt, slot, busy, wrap, timeout
   );

   modport slave (
      input  enable, req, done,
      output gnt, slot, busy, wrap, timeout
   );
endinterface

// File: rtl/decade_slot_arbiter.sv
// Ten-slot round-robin arbiter with a decimal (0..9) slot pointer.
// A slot is granted for at most MAX_HOLD consecutive cycles; release
// happens on done, on the request dropping, or on the hold limit.
// Optional feature macro: SKIP_IDLE_SLOTS_EN
//   undefined - fixed TDM walk, pointer steps one slot per idle cycle
//   defined   - pointer jumps straight to the next requesting slot
module decade_slot_arbiter #(
   parameter int unsigned MAX_HOLD = 15
) (
   input logic                  clk,
   input logic                  reset,
   decade_slot_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      SCAN = 2'b00,
      BUSY = 2'b01
   } state_t;

   localparam logic [3:0] C_MAX_HOLD = 4'(MAX_HOLD);

   state_t     r_state;
   logic [3:0] r_slot;
   logic [9:0] r_gnt;
   logic       r_busy;
   logic       r_wrap;
   logic       r_timeout;
   logic [3:0] r_hold;

   state_t     w_state;
   logic [3:0] w_slot;
   logic [9:0] w_gnt;
   logic       w_busy;
   logic       w_wrap;
   logic       w_timeout;
   logic [3:0] w_hold;
   logic       w_reqAtSlot;

   // Decimal increment so the pointer can never show 10..15.
   function automatic logic [3:0] nextSlot(input logic [3:0] s);
      return (s >= 4'd9) ? 4'd0 : s + 4'd1;
   endfunction

   assign w_reqAtSlot = (r_slot <= 4'd9) ? bus.req[r_slot] : 1'b0;

`ifdef SKIP_IDLE_SLOTS_EN
   logic       w_found;
   logic [3:0] w_pick;
   logic [4:0] w_idx;

   // Circular search from the current pointer; scanning from the far end
   // backwards lets the nearest requester overwrite the pick last.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_slot;
      w_idx   = 5'd0;
      for (int k = 9; k >= 0; k--) begin
         w_idx = {1'b0, r_slot} + 5'(k);
         if (w_idx >= 5'd10) begin
            w_idx = w_idx - 5'd10;
         end
         if (bus.req[w_idx[3:0]]) begin
            w_found = 1'b1;
            w_pick  = w_idx[3:0];
         end
      end
   end
`endif

   // Next-state and next-output decode for the SCAN/BUSY machine.
   always_comb begin
      w_state   = r_state;
      w_slot    = r_slot;
      w_gnt     = r_gnt;
      w_busy    = r_busy;
      w_hold    = r_hold;
      w_wrap    = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         SCAN: begin
            w_gnt  = '0;
            w_busy = 1'b0;
            w_hold = 4'd0;
            if (bus.enable) begin
`ifdef SKIP_IDLE_SLOTS_EN
               if (w_found) begin
                  w_state = BUSY;
                  w_slot  = w_pick;
                  w_gnt   = 10'd1 << w_pick;
                  w_busy  = 1'b1;
                  w_hold  = 4'd1;
                  w_wrap  = (w_pick < r_slot);
               end
`else
               if (w_reqAtSlot) begin
                  w_state = BUSY;
                  w_gnt   = 10'd1 << r_slot;
                  w_busy  = 1'b1;
                  w_hold  = 4'd1;
               end else begin
                  w_slot = nextSlot(r_slot);
                  w_wrap = (r_slot == 4'd9);
               end
`endif
            end
         end
         BUSY: begin
            if (bus.done || !w_reqAtSlot || (r_hold >= C_MAX_HOLD)) begin
               w_state   = SCAN;
               w_gnt     = '0;
               w_busy    = 1'b0;
               w_hold    = 4'd0;
               w_slot    = nextSlot(r_slot);
               w_wrap    = (r_slot == 4'd9);
               w_timeout = !bus.done && w_reqAtSlot;
            end else if (r_hold != 4'hF) begin
               w_hold = r_hold + 4'd1;
            end
         end
         default: begin
            w_state = SCAN;
            w_gnt   = '0;
            w_busy  = 1'b0;
            w_hold  = 4'd0;
         end
      endcase
   end

   // State and registered outputs, with reset overriding everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= SCAN;
         r_slot    <= 4'd0;
         r_gnt     <= '0;
         r_busy    <= 1'b0;
         r_wrap    <= 1'b0;
         r_timeout <= 1'b0;
         r_hold    <= 4'd0;
      end else begin
         r_state   <= w_state;
         r_slot    <= w_slot;
         r_gnt     <= w_gnt;
         r_busy    <= w_busy;
         r_wrap    <= w_wrap;
         r_timeout <= w_timeout;
         r_hold    <= w_hold;
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.slot    = r_slot;
   assign bus.busy    = r_busy;
   assign bus.wrap    = r_wrap;
   assign bus.timeout = r_timeout;

endmodule

// File: doc/decade_slot_arbiter.md
DECADE_SLOT_ARBITER -- requirements
Module: decade_slot_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 15, SHALL set the maximum consecutive grant cycles per slot (legal 1..15).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  active-high; when 0, slot scanning SHALL freeze.
REQ-005 req  input  10  per-slot request, bit i = requester i.
REQ-006 done  input  1  granted requester finished; sampled only while busy=1.
REQ-007 gnt  output  10  registered grant, one-hot or all-zero.
REQ-008 slot  output  4  current pointer value, 0..9.
REQ-009 busy  output  1  high while a grant is held.
REQ-010 wrap  output  1  one-cycle pulse when the pointer moves 9->0.
REQ-011 timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-012 FSM states SHALL be SCAN and BUSY only; any other encoding SHALL return to SCAN next cycle.
REQ-013 Pointer SHALL hold 0..9 only; increment from 9 SHALL yield 0; values 10..15 SHALL never appear on slot.
REQ-014 SCAN, enable=1, req[slot]=1: next cycle gnt[slot]=1, busy=1, state BUSY, hold count=1.
REQ-015 SCAN, enable=1, req[slot]=0: behaviour per REQ-026/REQ-027.
REQ-016 SCAN, enable=0: pointer, gnt, and state SHALL be unchanged; gnt stays 0.
REQ-017 Grant latency SHALL be exactly 1 cycle from the sampling edge at which the request is seen.
REQ-018 BUSY: gnt SHALL remain constant and one-hot; enable SHALL NOT abort a grant.
REQ-019 BUSY release condition: done=1, OR req[slot]=0, OR hold count=MAX_HOLD.
REQ-020 On release: next cycle gnt=0, busy=0, pointer=slot+1 mod 10, state SCAN.
REQ-021 Simultaneous release conditions SHALL produce exactly one release; timeout SHALL pulse only if done=0 and req[slot]=1 at hold count=MAX_HOLD.
REQ-022 After any release, at least one cycle with gnt=0 SHALL occur before the next grant.
REQ-023 Hold count SHALL be 4 bits, increment once per BUSY cycle, and never wrap.
REQ-024 wrap SHALL assert in the cycle slot first shows 0 after showing 9, from either a scan step or a release.
REQ-025 done while busy=0 SHALL be ignored.

Configuration
REQ-026 Macro SKIP_IDLE_SLOTS_EN defined: in SCAN with enable=1, the arbiter SHALL pick the first i with req[i]=1 in circular order starting at slot, grant it next cycle, and set slot=i; if req=0, pointer holds; wrap pulses if the search crosses 9->0.
REQ-027 SKIP_IDLE_SLOTS_EN undefined: in SCAN with enable=1 and req[slot]=0, the pointer SHALL advance by exactly one slot per cycle (fixed TDM walk, full idle lap = 10 cycles).

Reset
REQ-028 reset=1 at a clock edge: next cycle gnt=0, slot=0, busy=0, wrap=0, timeout=0, hold count=0, state SCAN.
REQ-029 Reset SHALL take priority over enable, req, and done, including mid-grant (BUSY aborted, no timeout or wrap pulse).
REQ-030 First grant after reset SHALL be evaluated starting from slot 0.

Verification
REQ-031 Reset, req=10'h000, enable=1, no SKIP: slot steps 0,1,...,9,0; wrap pulses once per 10 cycles; gnt stays 0.
REQ-032 No SKIP, req=10'h010 held, done pulsed 3 cycles after grant: gnt=10'h010 when slot=4 for 3 cycles, then gnt=0, slot=5.
REQ-033 req[2]=1 held, done=0, MAX_HOLD=15: gnt[2] high exactly 15 cycles, timeout pulses once, slot moves to 3.
REQ-034 SKIP_IDLE_SLOTS_EN, slot=8, req=10'h003: next cycle gnt=10'h001, slot=0, wrap=1; after release, gnt=10'h002 after one idle cycle.
REQ-035 reset asserted during BUSY on slot 6: next cycle gnt=0, busy=0, slot=0, no timeout pulse.
REQ-036 enable=0 at slot 3 for 5 cycles with req=0: slot stays 3; enable=1 resumes stepping to 4.
